// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared core types: load/store function codes and data-memory
//            responder state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

    typedef enum logic [3:0] {
        LS_NOP = 4'd0,
        LS_LW  = 4'd1,
        LS_LH  = 4'd2,
        LS_LB  = 4'd3,
        LS_LHU = 4'd4,
        LS_LBU = 4'd5,
        LS_SW  = 4'd6,
        LS_SH  = 4'd7,
        LS_SB  = 4'd8
    } load_store_func_code;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_DEFAULT_LATENCY = 2;

    // Codes above LS_SB are unassigned and must be reported as faults.
    function automatic logic ls_code_is_legal(input logic [3:0] code);
        return code <= LS_SB;
    endfunction

    function automatic logic ls_code_is_access(input logic [3:0] code);
        return (code != LS_NOP) && (code <= LS_SB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Little-endian lane steering for loads/stores: byte enables,
//            replicated write data, extended read data and alignment check.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import core_pkg::*;
(
    input  load_store_func_code i_func,
    input  logic [1:0]          i_addr_lo,
    input  logic [31:0]         i_wdata,
    input  logic [31:0]         i_rdata_raw,
    output logic [3:0]          o_be,
    output logic [31:0]         o_wdata_lane,
    output logic [31:0]         o_rdata_ext,
    output logic                o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata_raw[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata_raw[31:16] : i_rdata_raw[15:0];

    // Store data is replicated across lanes so the enables alone pick the target.
    always_comb begin
        o_be         = 4'b0000;
        o_wdata_lane = 32'h0000_0000;
        o_rdata_ext  = 32'h0000_0000;
        o_misaligned = 1'b0;
        case (i_func)
            LS_LW: begin
                o_misaligned = (i_addr_lo != 2'b00);
                o_rdata_ext  = i_rdata_raw;
            end
            LS_LH: begin
                o_misaligned = i_addr_lo[0];
                o_rdata_ext  = {{16{w_half[15]}}, w_half};
            end
            LS_LHU: begin
                o_misaligned = i_addr_lo[0];
                o_rdata_ext  = {16'h0000, w_half};
            end
            LS_LB: begin
                o_rdata_ext  = {{24{w_byte[7]}}, w_byte};
            end
            LS_LBU: begin
                o_rdata_ext  = {24'h00_0000, w_byte};
            end
            LS_SW: begin
                o_misaligned = (i_addr_lo != 2'b00);
                o_be         = 4'b1111;
                o_wdata_lane = i_wdata;
            end
            LS_SH: begin
                o_misaligned = i_addr_lo[0];
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_lane = {2{i_wdata[15:0]}};
            end
            LS_SB: begin
                o_be         = 4'b0001 << i_addr_lo;
                o_wdata_lane = {4{i_wdata[7:0]}};
            end
            default: begin
                o_be         = 4'b0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency data-memory responder for the core load/store
//            interface, with range/illegal-code fault and misalignment flags.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import core_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = DMEM_DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  req_func_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_misaligned_o,
    output logic        rsp_fault_o
);

    localparam int c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int c_cnt_w = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);
    localparam logic [29:0]        c_depth    = 30'(DEPTH_WORDS);

    dmem_state_e         r_state;
    dmem_state_e         w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [3:0]          r_func;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_misaligned;
    logic                r_fault;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_accept;
    logic                w_access;
    logic                w_commit;
    logic                w_in_range;
    logic                w_fault;
    logic                w_misaligned;
    logic                w_error;
    logic [c_idx_w-1:0]  w_idx;
    logic [31:0]         w_rdata_raw;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata_lane;
    logic [31:0]         w_rdata_ext;

    assign req_ready_o      = (r_state == DMEM_IDLE);
    assign rsp_valid_o      = (r_state == DMEM_RESP);
    assign rsp_rdata_o      = r_rdata;
    assign rsp_misaligned_o = r_misaligned;
    assign rsp_fault_o      = r_fault;

    assign w_accept   = req_valid_i & req_ready_o;
    assign w_access   = (r_state == DMEM_BUSY) && (r_cnt == '0);
    assign w_in_range = (r_addr[31:2] < c_depth);
    assign w_idx      = r_addr[c_idx_w+1:2];
    assign w_fault    = !ls_code_is_legal(r_func) ||
                        (ls_code_is_access(r_func) && !w_in_range);
    assign w_error    = w_fault | w_misaligned;
    // A reset landing on the access edge cancels the store as well.
    assign w_commit   = w_access & ~w_error & ~rst;

    assign w_rdata_raw = r_mem[w_idx];

    dmem_lane_align u_lane_align (
        .i_func       (load_store_func_code'(r_func)),
        .i_addr_lo    (r_addr[1:0]),
        .i_wdata      (r_wdata),
        .i_rdata_raw  (w_rdata_raw),
        .o_be         (w_be),
        .o_wdata_lane (w_wdata_lane),
        .o_rdata_ext  (w_rdata_ext),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DMEM_IDLE: if (w_accept)       w_state_nxt = DMEM_BUSY;
            DMEM_BUSY: if (r_cnt == '0)    w_state_nxt = DMEM_RESP;
            DMEM_RESP: if (rsp_ready_i)    w_state_nxt = DMEM_IDLE;
            default:                       w_state_nxt = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= DMEM_IDLE;
            r_cnt        <= '0;
            r_rdata      <= 32'h0000_0000;
            r_misaligned <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= c_cnt_load;
            end else if ((r_state == DMEM_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access) begin
                r_rdata      <= w_error ? 32'h0000_0000 : w_rdata_ext;
                r_misaligned <= w_misaligned;
                r_fault      <= w_fault;
            end
        end
    end

    // Request capture needs no reset: it is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_func  <= req_func_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed + randomized self-checking bench for dmem_responder
//            against a byte-addressed reference memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    import core_pkg::*;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_func;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        rsp_fault;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] model_mem [DEPTH*4];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_func_i       (req_func),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_rdata_o      (rsp_rdata),
        .rsp_misaligned_o (rsp_misaligned),
        .rsp_fault_o      (rsp_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, loads/stores by plain byte arithmetic.
    task automatic model_access(input logic [3:0] f, input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic mis, output logic flt);
        int unsigned word;
        int unsigned base;
        shortint     h;
        byte         b;
        word = a >> 2;
        flt  = (f > 4'd8) || ((f != 4'd0) && (word >= DEPTH));
        mis  = 1'b0;
        if (f == LS_LW || f == LS_SW)                 mis = (a % 4) != 0;
        if (f == LS_LH || f == LS_LHU || f == LS_SH)  mis = (a % 2) != 0;
        rd = 32'h0;
        if (f == LS_NOP || flt || mis) return;
        base = a;
        case (f)
            LS_LW:  rd = {model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]};
            LS_LH:  begin h = {model_mem[base+1], model_mem[base]}; rd = 32'(int'(h)); end
            LS_LHU: rd = {16'h0, model_mem[base+1], model_mem[base]};
            LS_LB:  begin b = model_mem[base]; rd = 32'(int'(b)); end
            LS_LBU: rd = {24'h0, model_mem[base]};
            LS_SW:  for (int i = 0; i < 4; i++) model_mem[base+i] = 8'(wd >> (8*i));
            LS_SH:  for (int i = 0; i < 2; i++) model_mem[base+i] = 8'(wd >> (8*i));
            LS_SB:  model_mem[base] = wd[7:0];
            default: rd = 32'h0;
        endcase
    endtask

    task automatic transact(input logic [3:0] f, input logic [31:0] a, input logic [31:0] wd,
                            input int hold, input string tag);
        logic [31:0] erd;
        logic        emis;
        logic        eflt;
        int          lat;
        @(negedge clk);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_func  = f;
        req_addr  = a;
        req_wdata = wd;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_func  = 4'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(LAT));
        model_access(f, a, wd, erd, emis, eflt);
        check({tag, ".rdata"}, rsp_rdata, erd);
        check({tag, ".misaligned"}, 32'(rsp_misaligned), 32'(emis));
        check({tag, ".fault"}, 32'(rsp_fault), 32'(eflt));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_func  = LS_SW;
            req_addr  = 32'h0;
            req_wdata = $urandom;
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".hold_rdata"}, rsp_rdata, erd);
            check({tag, ".hold_flags"}, {30'd0, rsp_fault, rsp_misaligned}, {30'd0, eflt, emis});
            check({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".valid_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int unsigned sel;
        logic [3:0]  rf;
        logic [31:0] ra;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_func  = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH*4; i++) model_mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset.req_ready",  32'(req_ready), 32'd1);
        check("reset.rsp_valid",  32'(rsp_valid), 32'd0);
        check("reset.rdata",      rsp_rdata,      32'd0);
        check("reset.misaligned", 32'(rsp_misaligned), 32'd0);
        check("reset.fault",      32'(rsp_fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Array contents are undefined after power-up; define the working region.
        for (int w = 0; w < 16; w++) transact(LS_SW, 32'(4*w), 32'h0, 0, "init");

        transact(LS_SW,  32'h10, 32'hDEADBEEF, 0, "sw_10");
        transact(LS_LW,  32'h10, 32'h0,        0, "lw_10");
        transact(LS_SB,  32'h13, 32'h0000007F, 0, "sb_13");
        transact(LS_LB,  32'h13, 32'h0,        0, "lb_13");
        transact(LS_LBU, 32'h10, 32'h0,        0, "lbu_10");
        transact(LS_LB,  32'h10, 32'h0,        0, "lb_10");
        transact(LS_LW,  32'h10, 32'h0,        0, "lw_10_merged");
        transact(LS_SH,  32'h22, 32'h00008001, 0, "sh_22");
        transact(LS_LH,  32'h22, 32'h0,        0, "lh_22");
        transact(LS_LHU, 32'h22, 32'h0,        0, "lhu_22");
        transact(LS_SH,  32'h21, 32'hFFFFFFFF, 0, "sh_21_misaligned");
        transact(LS_LH,  32'h21, 32'h0,        0, "lh_21_misaligned");
        transact(LS_LW,  32'h20, 32'h0,        0, "lw_20_untouched");
        transact(LS_SW,  32'(4*DEPTH),     32'hA5A5A5A5, 0, "sw_out_of_range");
        transact(LS_SW,  32'(4*DEPTH + 1), 32'hA5A5A5A5, 0, "sw_oor_misaligned");
        transact(LS_LW,  32'h0,  32'h0,        0, "lw_0_after_oor");
        transact(4'hF,   32'h10, 32'h11111111, 0, "illegal_code");
        transact(LS_NOP, 32'h10, 32'h22222222, 0, "nop");
        transact(LS_LW,  32'h10, 32'h0,        5, "backpressure");

        // Reset while a store is still counting down: it must never land.
        @(negedge clk);
        req_valid = 1'b1;
        req_func  = LS_SW;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset.req_ready",  32'(req_ready), 32'd1);
        check("midreset.rsp_valid",  32'(rsp_valid), 32'd0);
        check("midreset.rdata",      rsp_rdata,      32'd0);
        check("midreset.flags",      {30'd0, rsp_fault, rsp_misaligned}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("midreset.quiet", 32'(rsp_valid), 32'd0);
        end
        transact(LS_LW, 32'h30, 32'h0, 0, "lw_30_after_reset");

        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 19);
            if (sel < 2) begin
                rf = 4'($urandom_range(9, 15));
                ra = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end else begin
                rf = 4'($urandom_range(0, 8));
                ra = 32'($urandom_range(0, 63));
                if (sel == 2 && rf != 4'd0) ra = 32'(4*DEPTH) + 32'($urandom_range(0, 4095));
            end
            transact(rf, ra, $urandom, int'($urandom_range(0, 2)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
